// File: rtl/screen_memsrv_if.sv
// Bundles the screen read port, the CPU access port and the single-port RAM port
// of the screen memory server.
interface screen_memsrv_if #(
  parameter int DW     = 16,
  parameter int MEM_AW = 15
);
  logic              mem_ce;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_vld;
  logic [DW-1:0]     mem_dat;

  logic              cpu_ce;
  logic              cpu_we;
  logic [MEM_AW-1:0] cpu_addr;
  logic [DW-1:0]     cpu_wdat;
  logic              cpu_rdy;
  logic              cpu_rvld;
  logic [DW-1:0]     cpu_rdat;

  logic              ram_en;
  logic              ram_we;
  logic [MEM_AW-1:0] ram_addr;
  logic [DW-1:0]     ram_wdat;
  logic [DW-1:0]     ram_rdat;

  logic              ovf;

  modport slave (
    input  mem_ce, mem_addr, cpu_ce, cpu_we, cpu_addr, cpu_wdat, ram_rdat,
    output mem_vld, mem_dat, cpu_rdy, cpu_rvld, cpu_rdat,
           ram_en, ram_we, ram_addr, ram_wdat, ovf
  );

  modport master (
    output mem_ce, mem_addr, cpu_ce, cpu_we, cpu_addr, cpu_wdat, ram_rdat,
    input  mem_vld, mem_dat, cpu_rdy, cpu_rvld, cpu_rdat,
           ram_en, ram_we, ram_addr, ram_wdat, ovf
  );
endinterface

// File: rtl/screen_memsrv.sv
// Arbitrates a single-port RAM between a latency-bounded screen reader (2-entry
// request FIFO with starvation limit) and a CPU port with hold-until-ready requests.
module screen_memsrv #(
  parameter int                DW         = 16,
  parameter int                MEM_AW     = 15,
  parameter logic [MEM_AW-1:0] SCR_BASE   = 15'h4000,
  parameter int                SCR_WORDS  = 8192,
  parameter int                STARVE_MAX = 4
) (
  input logic             clk,
  input logic             rstn,
  screen_memsrv_if.slave  bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [MEM_AW:0]   SCR_LO     = {1'b0, SCR_BASE};
  localparam logic [MEM_AW:0]   SCR_HI     = SCR_LO + (MEM_AW + 1)'(SCR_WORDS);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_SCR  = 2'd1,
    TAG_CPU  = 2'd2,
    TAG_OOR  = 2'd3
  } tag_e;

  logic [MEM_AW-1:0] addr_q [2];
  logic              inr_q  [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  tag_e              tag_q, tag_d;
  logic              ovf_q, ovf_d;

  logic              head_vld, head_inr, urgent;
  logic [MEM_AW-1:0] head_addr;
  logic              scr_gnt, cpu_gnt, oor_pop;
  logic              pop, push, full, drop, req_inr;

  assign head_vld  = (cnt_q != 2'd0);
  assign head_addr = addr_q[rd_ptr_q];
  assign head_inr  = head_vld && inr_q[rd_ptr_q];
  assign urgent    = head_inr && (starve_q == STARVE_LIM);
  assign req_inr   = ({1'b0, bus.mem_addr} >= SCR_LO) && ({1'b0, bus.mem_addr} < SCR_HI);

  // Grant is gated by rstn so nothing reaches the RAM or CPU while held in reset.
  // An out-of-range head rides along a CPU write, but not a CPU read: both would
  // need the single return slot in the following cycle.
  always_comb begin
    scr_gnt = 1'b0;
    cpu_gnt = 1'b0;
    oor_pop = 1'b0;
    if (rstn) begin
      if (urgent) begin
        scr_gnt = 1'b1;
      end else if (bus.cpu_ce) begin
        cpu_gnt = 1'b1;
        oor_pop = head_vld && !head_inr && bus.cpu_we;
      end else if (head_vld) begin
        scr_gnt = head_inr;
        oor_pop = !head_inr;
      end
    end
  end

  assign pop  = scr_gnt || oor_pop;
  assign full = (cnt_q == 2'd2);
  assign push = bus.mem_ce && (!full || pop);
  assign drop = bus.mem_ce && full && !pop;

  // ---------------- next-state logic ----------------
  always_comb begin
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    starve_d = starve_q;
    if (scr_gnt) begin
      starve_d = '0;
    end else if (head_inr && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end

    tag_d = TAG_NONE;
    if (scr_gnt) begin
      tag_d = TAG_SCR;
    end else if (cpu_gnt && !bus.cpu_we) begin
      tag_d = TAG_CPU;
    end else if (oor_pop) begin
      tag_d = TAG_OOR;
    end

    ovf_d = ovf_q || drop;
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      starve_q <= '0;
      tag_q    <= TAG_NONE;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      tag_q    <= tag_d;
      ovf_q    <= ovf_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        addr_q[gi] <= '0;
        inr_q[gi]  <= 1'b0;
      end else if (push && (wr_ptr_q == 1'(gi))) begin
        addr_q[gi] <= bus.mem_addr;
        inr_q[gi]  <= req_inr;
      end
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    bus.cpu_rdy  = cpu_gnt;
    bus.ram_en   = scr_gnt || cpu_gnt;
    bus.ram_we   = cpu_gnt && bus.cpu_we;
    bus.ram_addr = '0;
    bus.ram_wdat = '0;
    if (scr_gnt) begin
      bus.ram_addr = head_addr;
    end else if (cpu_gnt) begin
      bus.ram_addr = bus.cpu_addr;
      bus.ram_wdat = bus.cpu_wdat;
    end

    bus.mem_vld  = (tag_q == TAG_SCR) || (tag_q == TAG_OOR);
    bus.mem_dat  = (tag_q == TAG_SCR) ? bus.ram_rdat : '0;
    bus.cpu_rvld = (tag_q == TAG_CPU);
    bus.cpu_rdat = (tag_q == TAG_CPU) ? bus.ram_rdat : '0;
    bus.ovf      = ovf_q;
  end

endmodule
